spart_driver: RTL and testbench
===============================

// Module: spart_driver
// PURPOSE
//  Bus-master controller that sequences the SPART's 8-bit tri-state processor bus.
//  After reset it programs the baud divisor selected by br_cfg. It then polls RDA/TBR,
//  reads received bytes into a 4-deep echo FIFO and writes them back to the transmit
//  buffer, giving a stand-alone echo terminal.
//  Sits opposite the SPART bus interface and shares DATABUS with it.
// PARAMETERS
//  DIV_4800   16'd1301  divisor for br_cfg=2'b00 (100 MHz clk, 16x oversample)
//  DIV_9600   16'd650   divisor for br_cfg=2'b01
//  DIV_19200  16'd324   divisor for br_cfg=2'b10
//  DIV_38400  16'd162   divisor for br_cfg=2'b11
//  FIFO_DEPTH 4         echo buffer entries (power of 2)
// PORTS
//  clk        in    1  system clock
//  rst        in    1  synchronous reset, active-low
//  br_cfg     in    2  baud select (DIP switches), sampled every cycle
//  rda        in    1  SPART receive-data-available
//  tbr        in    1  SPART transmit-buffer-ready
//  iocs       out   1  SPART chip select
//  iorw       out   1  1=read (SPART drives bus), 0=write (driver drives bus)
//  ioaddr     out   2  00 rx/tx buffer, 01 status, 10 divisor low, 11 divisor high
//  databus    inout 8  shared bus; driven only when iocs=1 && iorw=0, else 8'hzz
//  cfg_done   out   1  divisor programmed for the current br_cfg
//  fifo_count out   3  echo FIFO occupancy, 0..4
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus=z,
//    cfg_done=0, FIFO empty (count 0, pointers 0), br_cfg_q<=br_cfg, last_srv=TX.
//  - All bus outputs are registered, state-decoded; each bus transaction is 1 cycle.
//  - CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=div[7:0]  -> CFG_HI.
//  - CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=div[15:8] -> IDLE; set cfg_done=1.
//  - div is latched from br_cfg_q on entry to CFG_LO; both bytes always use the same div.
//  - IDLE: iocs=0. Decision order:
//      1. br_cfg != br_cfg_q: br_cfg_q<=br_cfg, cfg_done<=0, -> CFG_LO (FIFO kept).
//      2. can_rx = rda && count<4; can_tx = tbr && count>0.
//         - Only one true: go to RX or TX.
//         - Both true: serve the side not equal to last_srv (alternate).
//      3. Neither true: stay in IDLE.
//  - RX: iocs=1, iorw=1, ioaddr=00. databus is captured into FIFO[wr_ptr] at the end of
//    the cycle; wr_ptr++, count++, last_srv=RX -> IDLE.
//  - TX: iocs=1, iorw=0, ioaddr=00, databus=FIFO[rd_ptr]. rd_ptr++, count--,
//    last_srv=TX -> IDLE.
//  - RX/TX always return through IDLE, so there is at least 1 idle cycle between
//    transactions. This lets SPART update rda/tbr before they are re-sampled.
//  - Full (count=4): rda is ignored; bytes stay in the SPART receive buffer.
//    Empty: tbr is ignored.
//  - Pointers are 2 bits and wrap 3->0; count is 3 bits, so count never overflows.
//  - rst asserted mid-transaction: next cycle shows the reset values (iocs=0, bus
//    released); the in-flight byte is dropped.
//  - Status address 01 is never issued (rda/tbr are wired directly).
// STRUCTURE
//  - spart_pkg: ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH), state
//    encoding (CFG_LO, CFG_HI, IDLE, RX, TX), divisor table function div_sel(br_cfg).
//  - Sub-module echo_fifo (FIFO_DEPTH x 8, push/pop/count, synchronous active-low
//    reset); FSM and bus drive stay in spart_driver.
// TESTING
//  1. Reset release, br_cfg=01: cycle1 ioaddr=10 db=8'h8A; cycle2 ioaddr=11 db=8'h02;
//     then cfg_done=1.
//  2. rda pulse, bus model returns 8'h41: RX cycle iorw=1; then tbr=1 -> TX cycle
//     drives 8'h41; fifo_count 0->1->0.
//  3. rda held, tbr=0, bytes 01..06: exactly 4 RX cycles, fifo_count=4, no 5th read.
//     tbr=1 then yields 01,02,03,04 in order.
//  4. rda=tbr=1 with count=2: transactions alternate RX,TX,RX,TX with an IDLE cycle
//     between each; count stays within 1..3.
//  5. br_cfg 01->11 while FIFO holds 2 bytes: cfg_done=0, writes 10:8'hA2, 11:8'h00;
//     FIFO still 2 and echoes correctly.
//  6. rst=0 during a TX cycle: next cycle iocs=0, databus=z, count=0, state=CFG_LO.
//  Checks: databus never driven while iorw=1; iocs never held >1 cycle.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-master echo driver: bus addresses,
// FSM encoding, echo buffer sizing and the baud divisor lookup.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam logic [15:0] DIV_4800  = 16'd1301;
    localparam logic [15:0] DIV_9600  = 16'd650;
    localparam logic [15:0] DIV_19200 = 16'd324;
    localparam logic [15:0] DIV_38400 = 16'd162;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        CFG_LO = 3'd0,
        CFG_HI = 3'd1,
        IDLE   = 3'd2,
        RX     = 3'd3,
        TX     = 3'd4
    } state_e;

    typedef enum logic {
        SRV_RX = 1'b0,
        SRV_TX = 1'b1
    } srv_e;

    function automatic logic [15:0] div_sel(input logic [1:0] cfg);
        logic [15:0] div;
        case (cfg)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Small byte FIFO that holds received characters until the transmitter can
// echo them. Head data is presented combinationally so a pop can latch it.
module echo_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic push_ok;
    logic pop_ok;

    // Overflow and underflow requests are dropped rather than corrupting state.
    assign push_ok = push_i && (count_q != FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/spart_driver.sv
// Bus master for the SPART processor interface: programs the baud divisor,
// then echoes every received byte back through a small buffer.
module spart_driver
    import spart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       br_cfg,
    input  logic             rda,
    input  logic             tbr,
    output logic             iocs,
    output logic             iorw,
    output logic [1:0]       ioaddr,
    inout  wire logic [7:0]  databus,
    output logic             cfg_done,
    output logic [CNT_W-1:0] fifo_count
);

    state_e      state_q;
    srv_e        last_srv_q;
    logic        iocs_q;
    logic        iorw_q;
    logic [1:0]  ioaddr_q;
    logic [7:0]  dout_q;
    logic        cfg_done_q;
    logic [1:0]  br_cfg_q;
    logic [15:0] div_q;

    logic [7:0]  fifo_head;
    logic        bus_free;
    logic        cfg_change;
    logic        can_rx;
    logic        can_tx;
    logic        pick_rx;
    logic        pick_tx;
    logic        issue_rx;
    logic        issue_tx;
    logic        fifo_push;

    // IDLE only decides once the bus has shown a released cycle, so rda/tbr
    // are always sampled after the SPART has reacted to the last access.
    assign bus_free   = (state_q == IDLE) && !iocs_q;
    assign cfg_change = (br_cfg != br_cfg_q);
    assign can_rx     = rda && (fifo_count != CNT_FULL);
    assign can_tx     = tbr && (fifo_count != '0);
    assign pick_rx    = can_rx && (!can_tx || (last_srv_q == SRV_TX));
    assign pick_tx    = can_tx && !pick_rx;
    assign issue_rx   = bus_free && !cfg_change && pick_rx;
    assign issue_tx   = bus_free && !cfg_change && pick_tx;

    // The read byte is on the bus for the whole RX cycle; take it at its end.
    assign fifo_push  = (state_q == RX);

    echo_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (issue_tx),
        .din_i   (databus),
        .dout_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CFG_LO;
            last_srv_q <= SRV_TX;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= ADDR_BUF;
            dout_q     <= 8'h00;
            cfg_done_q <= 1'b0;
            br_cfg_q   <= br_cfg;
            div_q      <= div_sel(br_cfg);
        end else begin
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= ADDR_BUF;
            case (state_q)
                CFG_LO: begin
                    iocs_q   <= 1'b1;
                    iorw_q   <= 1'b0;
                    ioaddr_q <= ADDR_DBL;
                    dout_q   <= div_q[7:0];
                    state_q  <= CFG_HI;
                end
                CFG_HI: begin
                    iocs_q     <= 1'b1;
                    iorw_q     <= 1'b0;
                    ioaddr_q   <= ADDR_DBH;
                    dout_q     <= div_q[15:8];
                    cfg_done_q <= 1'b1;
                    state_q    <= IDLE;
                end
                IDLE: begin
                    if (bus_free && cfg_change) begin
                        br_cfg_q   <= br_cfg;
                        div_q      <= div_sel(br_cfg);
                        cfg_done_q <= 1'b0;
                        state_q    <= CFG_LO;
                    end else if (issue_rx) begin
                        iocs_q     <= 1'b1;
                        last_srv_q <= SRV_RX;
                        state_q    <= RX;
                    end else if (issue_tx) begin
                        iocs_q     <= 1'b1;
                        iorw_q     <= 1'b0;
                        dout_q     <= fifo_head;
                        last_srv_q <= SRV_TX;
                        state_q    <= TX;
                    end
                end
                RX, TX: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= CFG_LO;
                end
            endcase
        end
    end

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign cfg_done = cfg_done_q;
    assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a cycle table for configuration and a single
// echo, then hand sequences for full-buffer, alternation, reprogramming and reset.
module tb_spart_driver;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       cfg_done;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int mon_err  = 0;
    int rx_idx   = 0;
    logic       prev_buf = 1'b0;
    logic [7:0] rx_src [64];
    logic [7:0] tx_log [$];

    always #5 clk = ~clk;

    spart_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .fifo_count (fifo_count)
    );

    // SPART side of the bus: answers reads from a byte script, logs writes.
    assign databus = (iocs && iorw) ? rx_src[rx_idx] : 8'hzz;

    always @(posedge clk) begin
        if (rst && iocs && iorw && ioaddr == ADDR_BUF) rx_idx <= rx_idx + 1;
        if (rst && iocs && !iorw && ioaddr == ADDR_BUF) tx_log.push_back(databus);
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (!iocs && databus !== 8'hzz) mon_err++;
            if (iocs && iorw && databus !== rx_src[rx_idx]) mon_err++;
            if (iocs && ioaddr == ADDR_BUF && prev_buf) mon_err++;
        end
        prev_buf = iocs && (ioaddr == ADDR_BUF);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_count(input logic [2:0] target, input string name);
        for (int i = 0; i < 40 && fifo_count !== target; i++) step();
        check(name, fifo_count, target);
    endtask

    task automatic wait_tx(input string name);
        for (int i = 0; i < 40 && !(iocs === 1'b1 && iorw === 1'b0 && ioaddr === ADDR_BUF); i++) step();
        check(name, {iocs, iorw, ioaddr}, 4'b1000);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] br;
        logic       rda;
        logic       tbr;
        logic       e_iocs;
        logic       e_iorw;
        logic [1:0] e_addr;
        logic       e_rel;
        logic [7:0] e_db;
        logic       e_done;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs [12];
    int   exp_kind [8];
    int   kind;

    initial begin
        for (int i = 0; i < 64; i++) rx_src[i] = 8'hC0 + 8'(i);
        rx_src[0] = 8'h41;
        for (int i = 1; i <= 6; i++) rx_src[i] = 8'(i);

        //           rst br     rda  tbr   iocs iorw addr   rel  db     done cnt
        vecs[0]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b0, 3'd0};
        vecs[2]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'h8A, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 8'h02, 1'b1, 3'd0};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 3'd0};
        vecs[5]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h41, 1'b1, 3'd0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 3'd1};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h41, 1'b1, 3'd0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 3'd0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 3'd0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 3'd0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 3'd0};

        exp_kind = '{1, 0, 2, 0, 1, 0, 2, 0};

        // Configuration after reset, one echo, and tbr ignored while empty.
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; br_cfg = vecs[i].br; rda = vecs[i].rda; tbr = vecs[i].tbr;
            step();
            check($sformatf("v%0d_iocs", i), iocs, vecs[i].e_iocs);
            check($sformatf("v%0d_iorw", i), iorw, vecs[i].e_iorw);
            check($sformatf("v%0d_addr", i), ioaddr, vecs[i].e_addr);
            if (vecs[i].e_rel) check($sformatf("v%0d_bus_released", i), databus === 8'hzz, 1);
            else               check($sformatf("v%0d_db", i), databus, vecs[i].e_db);
            check($sformatf("v%0d_cfg_done", i), cfg_done, vecs[i].e_done);
            check($sformatf("v%0d_count", i), fifo_count, vecs[i].e_cnt);
        end

        // Full buffer: rda held, exactly four reads, then in-order echo.
        begin
            int rx_before;
            rx_before = rx_idx;
            rda = 1'b1; tbr = 1'b0;
            for (int i = 0; i < 20; i++) step();
            check("t3_reads", rx_idx - rx_before, 4);
            check("t3_count_full", fifo_count, 3'd4);
            tx_log.delete();
            rda = 1'b0; tbr = 1'b1;
            for (int i = 0; i < 20; i++) step();
            check("t3_tx_num", tx_log.size(), 4);
            for (int i = 0; i < 4 && i < tx_log.size(); i++)
                check($sformatf("t3_tx%0d", i), tx_log[i], 8'(i + 1));
            check("t3_count_empty", fifo_count, 3'd0);
            tbr = 1'b0;
            step();
        end

        // Alternation with both sides ready and count starting at 2.
        rda = 1'b1; tbr = 1'b0;
        wait_count(3'd3, "t4_fill3");
        rda = 1'b0; tbr = 1'b1;
        wait_count(3'd2, "t4_drain2");
        tbr = 1'b0;
        step();
        rda = 1'b1; tbr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            kind = !iocs ? 0 : (iorw ? 1 : 2);
            check($sformatf("t4_kind%0d", i), kind, exp_kind[i]);
            check($sformatf("t4_range%0d", i), (fifo_count >= 3'd1) && (fifo_count <= 3'd3), 1);
        end
        rda = 1'b0; tbr = 1'b1;
        wait_count(3'd0, "t4_drain0");
        tbr = 1'b0;
        step();
        step();

        // Baud change with two bytes buffered.
        rx_src[rx_idx]     = 8'h5A;
        rx_src[rx_idx + 1] = 8'h6B;
        rda = 1'b1;
        wait_count(3'd2, "t5_fill2");
        rda = 1'b0; br_cfg = 2'b11;
        step();
        check("t5_gap_iocs", iocs, 1'b0);
        check("t5_cfg_cleared", cfg_done, 1'b0);
        step();
        check("t5_lo_bus", {iocs, iorw, ioaddr}, 4'b1010);
        check("t5_lo_db", databus, 8'hA2);
        step();
        check("t5_hi_bus", {iocs, iorw, ioaddr}, 4'b1011);
        check("t5_hi_db", databus, 8'h00);
        check("t5_cfg_done", cfg_done, 1'b1);
        step();
        check("t5_count_kept", fifo_count, 3'd2);
        tbr = 1'b1;
        wait_tx("t5_tx1_seen");
        check("t5_tx1_db", databus, 8'h5A);
        step();
        wait_tx("t5_tx2_seen");
        check("t5_tx2_db", databus, 8'h6B);
        tbr = 1'b0;
        step();
        check("t5_count_empty", fifo_count, 3'd0);

        // Reset during a TX cycle.
        rda = 1'b1;
        wait_count(3'd2, "t6_fill2");
        rda = 1'b0; tbr = 1'b1;
        wait_tx("t6_tx_seen");
        check("t6_count_in_tx", fifo_count, 3'd1);
        rst = 1'b0; tbr = 1'b0;
        step();
        check("t6_rst_iocs", iocs, 1'b0);
        check("t6_rst_iorw", iorw, 1'b1);
        check("t6_rst_bus_released", databus === 8'hzz, 1);
        check("t6_rst_count", fifo_count, 3'd0);
        check("t6_rst_cfg_done", cfg_done, 1'b0);
        rst = 1'b1;
        step();
        check("t6_lo_bus", {iocs, iorw, ioaddr}, 4'b1010);
        check("t6_lo_db", databus, 8'hA2);
        step();
        check("t6_hi_db", databus, 8'h00);
        step();

        check("bus_monitor_errors", mon_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
